// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for a 5-stage MIPS core: carries decoded control ID->EX->MEM->WB,
// inserts load-use bubbles, raises IF/ID flush on taken branch/jump, and picks EX forwarding sources.
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_regdst_i,
    input  logic              id_alusrc_i,
    input  logic              id_memtoreg_i,
    input  logic              id_regwr_i,
    input  logic              id_memwr_i,
    input  logic              id_memrd_i,
    input  logic              id_branch_i,
    input  logic              id_jump_i,
    input  logic [1:0]        id_aluop_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_eq_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              pc_branch_o,
    output logic              pc_jump_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic              mem_memrd_o,
    output logic              mem_memwr_o,
    output logic              wb_regwr_o,
    output logic              wb_memtoreg_o,
    output logic [REG_AW-1:0] wb_wr_reg_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              ex_memrd, ex_memwr, ex_regwr, ex_memtoreg;
    logic [REG_AW-1:0] ex_wr_reg;
    logic              mem_regwr, mem_memtoreg;
    logic [REG_AW-1:0] mem_wr_reg;
    logic [REG_AW-1:0] id_wr_reg;
    logic              hz;

    assign id_wr_reg = id_regdst_i ? id_rd_i : id_rt_i;

    // A load still in EX cannot supply its data to the instruction now in ID.
    assign hz = ex_memrd && (ex_wr_reg != '0) &&
                ((ex_wr_reg == id_rs_i) || (ex_wr_reg == id_rt_i));

    // A stalled branch/jump is held in ID and resolves once the load has moved on.
    assign stall_o     = hz;
    assign pc_branch_o = id_branch_i && id_eq_i && !hz;
    assign pc_jump_o   = id_jump_i && !hz;
    assign flush_o     = pc_branch_o || pc_jump_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i || hz) begin
            ex_alusrc_o <= 1'b0;
            ex_aluop_o  <= 2'b00;
            ex_rs_o     <= '0;
            ex_rt_o     <= '0;
            ex_memrd    <= 1'b0;
            ex_memwr    <= 1'b0;
            ex_regwr    <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_wr_reg   <= '0;
        end else begin
            ex_alusrc_o <= id_alusrc_i;
            ex_aluop_o  <= id_aluop_i;
            ex_rs_o     <= id_rs_i;
            ex_rt_o     <= id_rt_i;
            ex_memrd    <= id_memrd_i;
            ex_memwr    <= id_memwr_i;
            ex_regwr    <= id_regwr_i;
            ex_memtoreg <= id_memtoreg_i;
            ex_wr_reg   <= id_wr_reg;
        end
    end

    // EX/MEM and MEM/WB never stall.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_memrd_o   <= 1'b0;
            mem_memwr_o   <= 1'b0;
            mem_regwr     <= 1'b0;
            mem_memtoreg  <= 1'b0;
            mem_wr_reg    <= '0;
            wb_regwr_o    <= 1'b0;
            wb_memtoreg_o <= 1'b0;
            wb_wr_reg_o   <= '0;
        end else begin
            mem_memrd_o   <= ex_memrd;
            mem_memwr_o   <= ex_memwr;
            mem_regwr     <= ex_regwr;
            mem_memtoreg  <= ex_memtoreg;
            mem_wr_reg    <= ex_wr_reg;
            wb_regwr_o    <= mem_regwr;
            wb_memtoreg_o <= mem_memtoreg;
            wb_wr_reg_o   <= mem_wr_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (hz && (bubble_cnt_o != '1)) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

    // The younger result (EX/MEM) takes precedence over MEM/WB.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (mem_regwr && (mem_wr_reg != '0) && (mem_wr_reg == ex_rs_o)) begin
            fwd_a_o = 2'b10;
        end else if (wb_regwr_o && (wb_wr_reg_o != '0) && (wb_wr_reg_o == ex_rs_o)) begin
            fwd_a_o = 2'b01;
        end
        if (mem_regwr && (mem_wr_reg != '0) && (mem_wr_reg == ex_rt_o)) begin
            fwd_b_o = 2'b10;
        end else if (wb_regwr_o && (wb_wr_reg_o != '0) && (wb_wr_reg_o == ex_rt_o)) begin
            fwd_b_o = 2'b01;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: stimulus pushes time-stamped expectations,
// a negedge monitor pops and compares those due in the current cycle.
module tb_pipe_ctrl_unit;

    localparam int S_STALL = 0, S_FLUSH = 1, S_PCB = 2, S_PCJ = 3, S_EX_ALUSRC = 4,
                   S_EX_ALUOP = 5, S_EX_RS = 6, S_EX_RT = 7, S_MEM_RD = 8, S_MEM_WR = 9,
                   S_WB_REGWR = 10, S_WB_M2R = 11, S_WB_WR = 12, S_FWDA = 13, S_FWDB = 14,
                   S_BCNT = 15, S_BCNT_S = 16;

    logic clk = 1'b0;
    logic rst;
    logic regdst, alusrc, memtoreg, regwr, memwr, memrd, branch, jump, eq;
    logic [1:0] aluop;
    logic [4:0] rs, rt, rd;
    logic stall, flush, pcb, pcj, ex_alusrc, mem_rd, mem_wr, wb_regwr, wb_m2r;
    logic [1:0] ex_aluop, fwd_a, fwd_b;
    logic [4:0] ex_rs, ex_rt, wb_wr;
    logic [15:0] bcnt;
    logic s_stall, s_flush, s_pcb, s_pcj, s_ex_alusrc, s_mem_rd, s_mem_wr, s_wb_regwr, s_wb_m2r;
    logic [1:0] s_ex_aluop, s_fwd_a, s_fwd_b;
    logic [4:0] s_ex_rs, s_ex_rt, s_wb_wr;
    logic [3:0] s_bcnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [55:0] exp_q[$];   // {due cycle[31:0], signal id[7:0], expected value[15:0]}

    pipe_ctrl_unit dut (
        .clk_i(clk), .rst_i(rst),
        .id_regdst_i(regdst), .id_alusrc_i(alusrc), .id_memtoreg_i(memtoreg),
        .id_regwr_i(regwr), .id_memwr_i(memwr), .id_memrd_i(memrd),
        .id_branch_i(branch), .id_jump_i(jump), .id_aluop_i(aluop),
        .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_eq_i(eq),
        .stall_o(stall), .flush_o(flush), .pc_branch_o(pcb), .pc_jump_o(pcj),
        .ex_alusrc_o(ex_alusrc), .ex_aluop_o(ex_aluop), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
        .mem_memrd_o(mem_rd), .mem_memwr_o(mem_wr),
        .wb_regwr_o(wb_regwr), .wb_memtoreg_o(wb_m2r), .wb_wr_reg_o(wb_wr),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .bubble_cnt_o(bcnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    pipe_ctrl_unit #(.CNT_W(4)) u_small (
        .clk_i(clk), .rst_i(rst),
        .id_regdst_i(regdst), .id_alusrc_i(alusrc), .id_memtoreg_i(memtoreg),
        .id_regwr_i(regwr), .id_memwr_i(memwr), .id_memrd_i(memrd),
        .id_branch_i(branch), .id_jump_i(jump), .id_aluop_i(aluop),
        .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd), .id_eq_i(eq),
        .stall_o(s_stall), .flush_o(s_flush), .pc_branch_o(s_pcb), .pc_jump_o(s_pcj),
        .ex_alusrc_o(s_ex_alusrc), .ex_aluop_o(s_ex_aluop), .ex_rs_o(s_ex_rs), .ex_rt_o(s_ex_rt),
        .mem_memrd_o(s_mem_rd), .mem_memwr_o(s_mem_wr),
        .wb_regwr_o(s_wb_regwr), .wb_memtoreg_o(s_wb_m2r), .wb_wr_reg_o(s_wb_wr),
        .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b), .bubble_cnt_o(s_bcnt)
    );

    // clock/reset
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_sig(int s);
        case (s)
            S_STALL:     return {15'd0, stall};
            S_FLUSH:     return {15'd0, flush};
            S_PCB:       return {15'd0, pcb};
            S_PCJ:       return {15'd0, pcj};
            S_EX_ALUSRC: return {15'd0, ex_alusrc};
            S_EX_ALUOP:  return {14'd0, ex_aluop};
            S_EX_RS:     return {11'd0, ex_rs};
            S_EX_RT:     return {11'd0, ex_rt};
            S_MEM_RD:    return {15'd0, mem_rd};
            S_MEM_WR:    return {15'd0, mem_wr};
            S_WB_REGWR:  return {15'd0, wb_regwr};
            S_WB_M2R:    return {15'd0, wb_m2r};
            S_WB_WR:     return {11'd0, wb_wr};
            S_FWDA:      return {14'd0, fwd_a};
            S_FWDB:      return {14'd0, fwd_b};
            S_BCNT:      return bcnt;
            S_BCNT_S:    return {12'd0, s_bcnt};
            default:     return 16'hdead;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_STALL: return "stall";         S_FLUSH: return "flush";
            S_PCB: return "pc_branch";       S_PCJ: return "pc_jump";
            S_EX_ALUSRC: return "ex_alusrc"; S_EX_ALUOP: return "ex_aluop";
            S_EX_RS: return "ex_rs";         S_EX_RT: return "ex_rt";
            S_MEM_RD: return "mem_memrd";    S_MEM_WR: return "mem_memwr";
            S_WB_REGWR: return "wb_regwr";   S_WB_M2R: return "wb_memtoreg";
            S_WB_WR: return "wb_wr_reg";     S_FWDA: return "fwd_a";
            S_FWDB: return "fwd_b";          S_BCNT: return "bubble_cnt";
            S_BCNT_S: return "bubble_cnt_small";
            default: return "unknown";
        endcase
    endfunction

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            begin
                automatic logic [55:0] keep_q[$];
                for (int i = 0; i < exp_q.size(); i++) begin
                    automatic logic [55:0] e = exp_q[i];
                    if (int'(e[55:24]) == cyc) begin
                        automatic logic [15:0] act = get_sig(int'(e[23:16]));
                        checks++;
                        if (act !== e[15:0]) begin
                            errors++;
                            $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                                     sig_name(int'(e[23:16])), cyc, act, e[15:0]);
                        end
                    end else begin
                        keep_q.push_back(e);
                    end
                end
                exp_q = keep_q;
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_at(int dly, int sig, logic [15:0] v);
        exp_q.push_back({32'(cyc + dly), 8'(sig), v});
    endtask

    task automatic set_id(logic f_regdst, logic f_alusrc, logic f_m2r, logic f_regwr,
                          logic f_memwr, logic f_memrd, logic f_br, logic f_j,
                          logic [1:0] f_aluop, logic [4:0] f_rs, logic [4:0] f_rt,
                          logic [4:0] f_rd, logic f_eq);
        regdst = f_regdst; alusrc = f_alusrc; memtoreg = f_m2r; regwr = f_regwr;
        memwr = f_memwr; memrd = f_memrd; branch = f_br; jump = f_j;
        aluop = f_aluop; rs = f_rs; rt = f_rt; rd = f_rd; eq = f_eq;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0);
    endtask
    task automatic rtype(logic [4:0] a, logic [4:0] b, logic [4:0] d);
        set_id(1, 0, 0, 1, 0, 0, 0, 0, 2'b10, a, b, d, 0);
    endtask
    task automatic lw(logic [4:0] a, logic [4:0] t);
        set_id(0, 1, 1, 1, 0, 1, 0, 0, 2'b00, a, t, 5'd0, 0);
    endtask
    task automatic beq(logic [4:0] a, logic [4:0] b, logic e);
        set_id(0, 0, 0, 0, 0, 0, 1, 0, 2'b01, a, b, 5'd0, e);
    endtask
    task automatic jmp();
        set_id(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd0, 5'd0, 5'd0, 0);
    endtask
    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            nop();
        end
    endtask

    initial begin
        rst = 1'b0;
        rtype(5'd0, 5'd0, 5'd7);

        // reset held for two cycles with RegWrite asserted
        next_cycle();
        for (int s = S_EX_ALUSRC; s <= S_BCNT; s++) expect_at(0, s, 16'd0);
        next_cycle();
        expect_at(0, S_WB_REGWR, 0);
        expect_at(0, S_EX_ALUOP, 0);
        rst = 1'b1;
        expect_at(1, S_EX_ALUOP, 2);
        expect_at(1, S_WB_REGWR, 0);
        expect_at(2, S_WB_REGWR, 0);
        expect_at(3, S_WB_REGWR, 1);
        expect_at(3, S_WB_WR, 7);
        expect_at(4, S_WB_REGWR, 0);
        idle(4);

        // load-use: lw r8 then add using r8
        next_cycle(); lw(5'd2, 5'd8);
        expect_at(0, S_STALL, 0); expect_at(2, S_MEM_RD, 1);
        next_cycle(); rtype(5'd8, 5'd9, 5'd10);
        expect_at(0, S_STALL, 1); expect_at(0, S_FLUSH, 0);
        expect_at(0, S_EX_ALUSRC, 1); expect_at(0, S_EX_RT, 8);
        expect_at(1, S_EX_RS, 0); expect_at(1, S_EX_RT, 0);
        expect_at(1, S_EX_ALUSRC, 0); expect_at(1, S_EX_ALUOP, 0);
        expect_at(1, S_BCNT, 1);
        next_cycle(); rtype(5'd8, 5'd9, 5'd10);
        expect_at(0, S_STALL, 0);
        expect_at(1, S_EX_RS, 8); expect_at(1, S_FWDA, 1); expect_at(1, S_FWDB, 0);
        expect_at(1, S_WB_M2R, 1); expect_at(1, S_WB_WR, 8);
        idle(3);

        // forward priority: r3 in both MEM and WB
        next_cycle(); rtype(5'd1, 5'd2, 5'd3);
        next_cycle(); rtype(5'd4, 5'd5, 5'd3);
        next_cycle(); rtype(5'd3, 5'd3, 5'd6);
        expect_at(1, S_FWDA, 2); expect_at(1, S_FWDB, 2);
        idle(3);

        // destination r0 never forwards
        next_cycle(); rtype(5'd1, 5'd2, 5'd0);
        next_cycle(); rtype(5'd0, 5'd0, 5'd6);
        expect_at(1, S_FWDA, 0); expect_at(1, S_FWDB, 0);
        idle(3);

        // operand B from MEM/WB only
        next_cycle(); rtype(5'd1, 5'd2, 5'd11);
        next_cycle(); nop();
        next_cycle(); rtype(5'd1, 5'd11, 5'd12);
        expect_at(1, S_FWDB, 1); expect_at(1, S_FWDA, 0);

        // load into r0 never stalls
        next_cycle(); lw(5'd1, 5'd0);
        next_cycle(); rtype(5'd0, 5'd0, 5'd13);
        expect_at(0, S_STALL, 0);
        idle(3);

        // branch taken / not taken, jump
        next_cycle(); beq(5'd1, 5'd2, 1'b1);
        expect_at(0, S_PCB, 1); expect_at(0, S_FLUSH, 1); expect_at(0, S_PCJ, 0);
        expect_at(1, S_EX_ALUOP, 1);
        next_cycle(); beq(5'd1, 5'd2, 1'b0);
        expect_at(0, S_PCB, 0); expect_at(0, S_FLUSH, 0);
        next_cycle(); jmp();
        expect_at(0, S_PCJ, 1); expect_at(0, S_FLUSH, 1); expect_at(0, S_PCB, 0);
        idle(3);

        // stall has priority over a taken branch
        next_cycle(); lw(5'd1, 5'd5);
        next_cycle(); beq(5'd5, 5'd5, 1'b1);
        expect_at(0, S_STALL, 1); expect_at(0, S_FLUSH, 0); expect_at(0, S_PCB, 0);
        next_cycle(); beq(5'd5, 5'd5, 1'b1);
        expect_at(0, S_STALL, 0); expect_at(0, S_FLUSH, 1); expect_at(0, S_PCB, 1);
        expect_at(0, S_BCNT, 2);
        idle(3);

        // 19 more hazards: wide counter reaches 21, 4-bit copy holds 4'hF
        for (int i = 0; i < 19; i++) begin
            next_cycle(); lw(5'd0, 5'd7);
            next_cycle(); rtype(5'd7, 5'd0, 5'd9);
            expect_at(0, S_STALL, 1);
        end
        next_cycle(); nop();
        expect_at(0, S_BCNT, 21); expect_at(0, S_BCNT_S, 15);

        // reset mid-flight discards in-flight control
        next_cycle(); rtype(5'd1, 5'd2, 5'd14);
        next_cycle(); nop(); rst = 1'b0;
        next_cycle(); rst = 1'b1;
        expect_at(0, S_BCNT, 0); expect_at(0, S_BCNT_S, 0);
        expect_at(0, S_EX_ALUOP, 0); expect_at(1, S_WB_REGWR, 0);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
